// File: rtl/seq_stepper_if.sv
// Command handshake bundle for seq_stepper: host drives RUN/STEP/HOLD/RESTART with an argument.
interface seq_stepper_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/seq_stepper.sv
// Command-driven initiator for the 3-state odd/even sequencer; drives pause/restart, counts terminals.
// Optional response checker enabled by defining SEQ_STEPPER_CHECKER_EN.
module seq_stepper #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_stepper_if.slave     cmd,
  output logic             o_pause,
  output logic             o_restart,
  input  logic [1:0]       i_fsm_state,
  input  logic             i_fsm_odd,
  input  logic             i_fsm_even,
  input  logic             i_fsm_terminal,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_seq_count,
  output logic [2:0]       o_err
);
  localparam logic [1:0] OpRun     = 2'b00;
  localparam logic [1:0] OpStep    = 2'b01;
  localparam logic [1:0] OpRestart = 2'b11;

  localparam logic [1:0] FsmFirst  = 2'b11;
  localparam logic [1:0] FsmSecond = 2'b01;
  localparam logic [1:0] FsmThird  = 2'b10;

  typedef enum logic [2:0] {StIdle, StRun, StStep, StHold, StRestart} ctrl_e;

  ctrl_e            r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_seq_count;
  logic             r_pause, w_pause_nxt;
  logic             r_restart, w_restart_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;

  assign cmd.cmd_ready = (r_state == StIdle);
  assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_pause     <= 1'b1;
      r_restart   <= 1'b0;
      r_done      <= 1'b0;
      r_seq_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pause     <= w_pause_nxt;
      r_restart   <= w_restart_nxt;
      r_done      <= w_done_nxt;
      if (i_fsm_terminal) r_seq_count <= r_seq_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pause_nxt   = r_pause;
    w_restart_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_pause_nxt = 1'b1;
        if (w_accept) begin
          w_cnt_nxt = cmd.cmd_arg;
          if (cmd.cmd_op == OpRestart) begin
            w_state_nxt   = StRestart;
            w_restart_nxt = 1'b1;
          end else if (cmd.cmd_arg == '0) begin
            // Zero-length command completes immediately without touching the FSM.
            w_done_nxt = 1'b1;
          end else begin
            case (cmd.cmd_op)
              OpRun: begin
                w_state_nxt = StRun;
                w_pause_nxt = 1'b0;
              end
              OpStep: begin
                w_state_nxt = StStep;
                w_pause_nxt = 1'b0;
              end
              default: w_state_nxt = StHold;
            endcase
          end
        end
      end
      StRun: begin
        w_pause_nxt = 1'b0;
        if (i_fsm_terminal) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          // Pausing on the last terminal edge parks the FSM in FIRST.
          if (r_cnt == CNT_W'(1)) begin
            w_pause_nxt = 1'b1;
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      StStep, StHold: begin
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_pause_nxt = (r_state == StHold);
        if (r_cnt == CNT_W'(1)) begin
          w_pause_nxt = 1'b1;
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      StRestart: begin
        w_pause_nxt = 1'b1;
        w_state_nxt = StIdle;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_pause_nxt = 1'b1;
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_pause     = r_pause;
  assign o_restart   = r_restart;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_seq_count = r_seq_count;

`ifdef SEQ_STEPPER_CHECKER_EN
  logic [1:0] r_prev_state;
  logic       r_prev_pause;
  logic       r_prev_restart;
  logic       r_chk_en;
  logic [2:0] r_err;
  logic [1:0] w_exp_state;
  logic [2:0] w_err_now;

  always_comb begin
    w_exp_state = FsmFirst;
    if (r_prev_restart) begin
      w_exp_state = FsmFirst;
    end else if (r_prev_pause) begin
      w_exp_state = r_prev_state;
    end else begin
      case (r_prev_state)
        FsmFirst:  w_exp_state = FsmSecond;
        FsmSecond: w_exp_state = FsmThird;
        default:   w_exp_state = FsmFirst;
      endcase
    end
    w_err_now[0] = (i_fsm_state == 2'b00);
    w_err_now[1] = (i_fsm_state != w_exp_state);
    w_err_now[2] = (i_fsm_odd != ((i_fsm_state == FsmFirst) | (i_fsm_state == FsmThird))) |
                   (i_fsm_even != (i_fsm_state == FsmSecond)) |
                   (i_fsm_terminal != ((i_fsm_state == FsmThird) & (r_restart | ~r_pause)));
  end

  // r_chk_en skips the first cycle after reset, before a valid history exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_state   <= FsmFirst;
      r_prev_pause   <= 1'b1;
      r_prev_restart <= 1'b0;
      r_chk_en       <= 1'b0;
      r_err          <= 3'b000;
    end else begin
      r_prev_state   <= i_fsm_state;
      r_prev_pause   <= r_pause;
      r_prev_restart <= r_restart;
      r_chk_en       <= 1'b1;
      if (r_chk_en) r_err <= r_err | w_err_now;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{i_fsm_state, i_fsm_odd, i_fsm_even};
  assign o_err    = 3'b000;
`endif

endmodule
